// File: rtl/stream_mux4_pkg.sv
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared types, constants and helpers for the 4-to-1 stream
//               combiner and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  // Output register occupancy; the state bit doubles as out_valid.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } mux_state_t;

  // Encode a one-hot (or all-zero) channel vector into its channel index.
  function automatic ch_sel_t onehot_to_sel(input logic [NUM_CH-1:0] oh);
    ch_sel_t sel;
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) sel = sel | ch_sel_t'(i);
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux4_if.sv
// ============================================================================
// Module      : stream_mux4_if
// Description : Bundle of the four valid/ready input channels and the tagged
//               output channel of the stream combiner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_mux4_if #(
  parameter int DATA_W = 8
);

  logic [stream_mux_pkg::NUM_CH-1:0]        in_valid;
  logic [stream_mux_pkg::NUM_CH*DATA_W-1:0] in_data;
  logic [stream_mux_pkg::NUM_CH-1:0]        in_ready;
  logic                                     out_valid;
  logic [DATA_W-1:0]                        out_data;
  stream_mux_pkg::ch_sel_t                  out_sel;
  logic                                     out_ready;

  // Producer/consumer side that feeds the combiner and drains its output.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // The combiner itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

`default_nettype wire

// File: rtl/stream_mux4_rr_arb4.sv
// ============================================================================
// Module      : rr_arb4
// Description : 4-request arbiter. Grants the first requester found when
//               searching from ptr upward (mod 4). With
//               STREAM_MUX4_FIXED_PRIO_EN defined the search always starts at
//               channel 0 (fixed priority, ch0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb4
  import stream_mux_pkg::*;
(
  input  wire logic [NUM_CH-1:0] req,
  input  wire ch_sel_t           ptr,
  input  wire logic              en,
  output logic [NUM_CH-1:0]      gnt,
  output ch_sel_t                gnt_idx
);

  ch_sel_t w_start;

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  // Search always begins at channel 0; ptr carries no information here.
  assign w_start = ptr & ch_sel_t'(0);
`else
  assign w_start = ptr;
`endif

  // Walk the channels in rotating order and grant the first requester.
  always_comb begin
    ch_sel_t w_idx;
    logic    w_found;
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = w_start + ch_sel_t'(k);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign gnt_idx = onehot_to_sel(gnt);

endmodule

`default_nettype wire

// File: rtl/stream_mux4.sv
// ============================================================================
// Module      : stream_mux4
// Description : 4-to-1 streaming combiner. Merges four valid/ready channels
//               onto one registered output word tagged with its source
//               channel. Round-robin arbitration by default; define
//               STREAM_MUX4_FIXED_PRIO_EN for fixed priority (ch0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux4
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  stream_mux4_if.slave   bus
);

  mux_state_t        r_state;
  logic [DATA_W-1:0] r_out_data;
  ch_sel_t           r_out_sel;
  ch_sel_t           w_ptr;

  logic              w_load;
  logic [NUM_CH-1:0] w_gnt;
  ch_sel_t           w_gnt_idx;
  logic              w_xfer;

  // The output register can take a word when empty or being drained.
  assign w_load = (r_state == EMPTY) || bus.out_ready;

  rr_arb4 u_arb (
    .req     (bus.in_valid),
    .ptr     (w_ptr),
    .en      (w_load && !rst),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // A grant is only issued to a valid channel, so any grant is a transfer.
  assign bus.in_ready = w_gnt;
  assign w_xfer       = |w_gnt;

  // Output register and FULL/EMPTY control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_out_data <= '0;
      r_out_sel  <= '0;
    end else if (w_xfer) begin
      r_state    <= FULL;
      r_out_data <= bus.in_data[w_gnt_idx*DATA_W +: DATA_W];
      r_out_sel  <= w_gnt_idx;
    end else if (bus.out_ready) begin
      r_state    <= EMPTY;
    end
  end

`ifdef STREAM_MUX4_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  ch_sel_t r_ptr;

  // Priority pointer moves past the winner, only on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_gnt_idx + ch_sel_t'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

`default_nettype wire
